external_clk: RTL and testbench



---
 rtl/external_clk_if.sv | 24 ++
 rtl/external_clk.sv | 116 +++++++++++
 tb/tb_external_clk.sv | 130 +++++++++++++
 3 files changed

// File: rtl/external_clk_if.sv
// external_clk_if: phase clocks, oscillator handshake and core resets
// produced by the clock/reset sequencer.
//   master - driven by external_clk
//   slave  - consumed by the SM83 core
interface external_clk_if;
  logic ADR_CLK_P,  ADR_CLK_N;
  logic DATA_CLK_P, DATA_CLK_N;
  logic INC_CLK_P,  INC_CLK_N;
  logic MAIN_CLK_P, MAIN_CLK_N;
  logic LATCH_CLK;
  logic OSC_ENA, OSC_STABLE, CLK_ENA;
  logic ASYNC_RESET, SYNC_RESET;

  modport master (
    output ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N,
           INC_CLK_P, INC_CLK_N, MAIN_CLK_P, MAIN_CLK_N, LATCH_CLK,
           OSC_ENA, OSC_STABLE, CLK_ENA, ASYNC_RESET, SYNC_RESET
  );
  modport slave (
    input  ADR_CLK_P, ADR_CLK_N, DATA_CLK_P, DATA_CLK_N,
           INC_CLK_P, INC_CLK_N, MAIN_CLK_P, MAIN_CLK_N, LATCH_CLK,
           OSC_ENA, OSC_STABLE, CLK_ENA, ASYNC_RESET, SYNC_RESET
  );
endinterface

// File: rtl/external_clk.sv
// external_clk: clock/reset sequencer for the SM83 core.
// Synchronizes RESET release, enables the oscillator, waits STABLE_CYCLES
// for it to settle, then runs an 8-phase M-cycle and holds SYNC_RESET for
// SYNC_RESET_MCYCLES complete M-cycles.
//   CLK   - free-running input clock (rising edge)
//   RESET - asynchronous active-high reset
//   bus   - phase clocks, oscillator handshake, core resets (master)
module external_clk #(
  parameter int STABLE_CYCLES      = 16,
  parameter int SYNC_RESET_MCYCLES = 1
) (
  input  logic           CLK,
  input  logic           RESET,
  external_clk_if.master bus
);
  localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [3:0] MCYC_MAX  = 4'(SYNC_RESET_MCYCLES);
  localparam logic [3:0] MCYC_LAST = 4'(SYNC_RESET_MCYCLES - 1);

  logic       rst_sync_q,    rst_sync_d;
  logic       async_reset_q, async_reset_d;
  logic       osc_ena_q,     osc_ena_d;
  logic       osc_stable_q,  osc_stable_d;
  logic       clk_ena_q,     clk_ena_d;
  logic       sync_reset_q,  sync_reset_d;
  logic [7:0] stab_cnt_q,    stab_cnt_d;
  logic [2:0] phase_q,       phase_d;
  logic [3:0] mcyc_cnt_q,    mcyc_cnt_d;
  logic       adr_q,   adr_d;
  logic       data_q,  data_d;
  logic       inc_q,   inc_d;
  logic       main_q,  main_d;
  logic       latch_q, latch_d;
  logic       mcyc_wrap;

  always_comb begin
    // Two-flop release synchronizer: rst_sync_q then async_reset_q.
    rst_sync_d    = 1'b0;
    async_reset_d = rst_sync_q;
    // OSC_ENA rises on the same edge ASYNC_RESET falls.
    osc_ena_d     = osc_ena_q | ~rst_sync_q;

    stab_cnt_d = stab_cnt_q;
    if (osc_ena_q && stab_cnt_q != STAB_MAX)
      stab_cnt_d = stab_cnt_q + 8'd1;
    osc_stable_d = osc_stable_q | (osc_ena_q && stab_cnt_q == STAB_LAST);
    clk_ena_d    = clk_ena_q | osc_stable_q;

    phase_d   = clk_ena_q ? phase_q + 3'd1 : 3'd0;
    mcyc_wrap = clk_ena_q && (phase_q == 3'd7);

    mcyc_cnt_d = mcyc_cnt_q;
    if (mcyc_wrap && mcyc_cnt_q != MCYC_MAX)
      mcyc_cnt_d = mcyc_cnt_q + 4'd1;
    sync_reset_d = sync_reset_q & ~(mcyc_wrap && mcyc_cnt_q == MCYC_LAST);

    // Decode the phase being entered so the registered outputs are valid
    // from the edge that starts that phase.
    adr_d   = clk_ena_d && (phase_d <= 3'd3);
    data_d  = clk_ena_d && (phase_d >= 3'd2) && (phase_d <= 3'd5);
    inc_d   = clk_ena_d && (phase_d >= 3'd4);
    main_d  = clk_ena_d && (phase_d >= 3'd6);
    latch_d = clk_ena_d && (phase_d == 3'd3);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rst_sync_q    <= 1'b1;
      async_reset_q <= 1'b1;
      osc_ena_q     <= 1'b0;
      osc_stable_q  <= 1'b0;
      clk_ena_q     <= 1'b0;
      sync_reset_q  <= 1'b1;
      stab_cnt_q    <= 8'd0;
      phase_q       <= 3'd0;
      mcyc_cnt_q    <= 4'd0;
      adr_q         <= 1'b0;
      data_q        <= 1'b0;
      inc_q         <= 1'b0;
      main_q        <= 1'b0;
      latch_q       <= 1'b0;
    end else begin
      rst_sync_q    <= rst_sync_d;
      async_reset_q <= async_reset_d;
      osc_ena_q     <= osc_ena_d;
      osc_stable_q  <= osc_stable_d;
      clk_ena_q     <= clk_ena_d;
      sync_reset_q  <= sync_reset_d;
      stab_cnt_q    <= stab_cnt_d;
      phase_q       <= phase_d;
      mcyc_cnt_q    <= mcyc_cnt_d;
      adr_q         <= adr_d;
      data_q        <= data_d;
      inc_q         <= inc_d;
      main_q        <= main_d;
      latch_q       <= latch_d;
    end
  end

  // _N outputs are plain inversions of flops, so they stay glitch-free.
  assign bus.ADR_CLK_P   = adr_q;
  assign bus.ADR_CLK_N   = ~adr_q;
  assign bus.DATA_CLK_P  = data_q;
  assign bus.DATA_CLK_N  = ~data_q;
  assign bus.INC_CLK_P   = inc_q;
  assign bus.INC_CLK_N   = ~inc_q;
  assign bus.MAIN_CLK_P  = main_q;
  assign bus.MAIN_CLK_N  = ~main_q;
  assign bus.LATCH_CLK   = latch_q;
  assign bus.OSC_ENA     = osc_ena_q;
  assign bus.OSC_STABLE  = osc_stable_q;
  assign bus.CLK_ENA     = clk_ena_q;
  assign bus.ASYNC_RESET = async_reset_q;
  assign bus.SYNC_RESET  = sync_reset_q;
endmodule

// File: tb/tb_external_clk.sv
module tb_external_clk;
  logic CLK = 1'b0;
  logic RESET;

  external_clk_if if0 ();
  external_clk_if if1 ();

  external_clk #(.STABLE_CYCLES(16), .SYNC_RESET_MCYCLES(1)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .bus(if0));
  external_clk #(.STABLE_CYCLES(4), .SYNC_RESET_MCYCLES(2)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .bus(if1));

  always #10 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {ADR_P,ADR_N,DATA_P,DATA_N,INC_P,INC_N,MAIN_P,MAIN_N,LATCH,
  //  OSC_ENA,OSC_STABLE,CLK_ENA,ASYNC_RESET,SYNC_RESET}
  logic [13:0] obs0, obs1;
  assign obs0 = {if0.ADR_CLK_P, if0.ADR_CLK_N, if0.DATA_CLK_P, if0.DATA_CLK_N,
                 if0.INC_CLK_P, if0.INC_CLK_N, if0.MAIN_CLK_P, if0.MAIN_CLK_N,
                 if0.LATCH_CLK, if0.OSC_ENA, if0.OSC_STABLE, if0.CLK_ENA,
                 if0.ASYNC_RESET, if0.SYNC_RESET};
  assign obs1 = {if1.ADR_CLK_P, if1.ADR_CLK_N, if1.DATA_CLK_P, if1.DATA_CLK_N,
                 if1.INC_CLK_P, if1.INC_CLK_N, if1.MAIN_CLK_P, if1.MAIN_CLK_N,
                 if1.LATCH_CLK, if1.OSC_ENA, if1.OSC_STABLE, if1.CLK_ENA,
                 if1.ASYNC_RESET, if1.SYNC_RESET};

  // Expected outputs after e rising edges with RESET low (e=0 in reset).
  function automatic logic [13:0] exp_vec(input int e, input int s, input int m);
    logic as, oe, st, ce, sr, adr, dat, inc, mn, lat;
    int ph;
    as = (e < 2);
    oe = (e >= 2);
    st = (e >= 2 + s);
    ce = (e >= 3 + s);
    sr = (e < 3 + s + 8 * m);
    adr = 1'b0; dat = 1'b0; inc = 1'b0; mn = 1'b0; lat = 1'b0;
    if (ce) begin
      ph  = (e - 3 - s) % 8;
      adr = (ph <= 3);
      dat = (ph >= 2) && (ph <= 5);
      inc = (ph >= 4);
      mn  = (ph >= 6);
      lat = (ph == 3);
    end
    return {adr, ~adr, dat, ~dat, inc, ~inc, mn, ~mn, lat, oe, st, ce, as, sr};
  endfunction

  typedef struct {
    int          e;
    logic [13:0] x0;
    logic [13:0] x1;
  } exp_t;
  exp_t q[$];

  int e = 0;

  always @(posedge RESET) e = 0;

  // Model side: one expected entry per rising edge.
  always @(posedge CLK) begin
    if (RESET) e = 0;
    else       e = e + 1;
    q.push_back('{e, exp_vec(e, 16, 1), exp_vec(e, 4, 2)});
  end

  int stab_rise0 = 0, stab_rise1 = 0, sr_fall0 = 0, sr_fall1 = 0;
  logic prev_st0 = 1'b0, prev_st1 = 1'b0, prev_sr0 = 1'b1, prev_sr1 = 1'b1;

  // DUT side: compare each sample half a period after its edge.
  always @(negedge CLK) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk($sformatf("d0 e%0d", x.e), 32'(obs0), 32'(x.x0));
      chk($sformatf("d1 e%0d", x.e), 32'(obs1), 32'(x.x1));
    end
    if (if0.OSC_STABLE === 1'b1 && !prev_st0) stab_rise0++;
    if (if1.OSC_STABLE === 1'b1 && !prev_st1) stab_rise1++;
    if (if0.SYNC_RESET === 1'b0 && prev_sr0)  sr_fall0++;
    if (if1.SYNC_RESET === 1'b0 && prev_sr1)  sr_fall1++;
    prev_st0 = (if0.OSC_STABLE === 1'b1);
    prev_st1 = (if1.OSC_STABLE === 1'b1);
    prev_sr0 = (if0.SYNC_RESET !== 1'b0);
    prev_sr1 = (if1.SYNC_RESET !== 1'b0);
  end

  initial begin
    int n;
    RESET = 1'b1;
    repeat (8) @(negedge CLK);
    RESET = 1'b0;

    // Run well past startup, then stop at a phase-5 sample of dut0.
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(e > 40 && ((e - 19) % 8) == 5) && n < 200);
    chk("phase5 reached", 32'(n < 200), 32'd1);

    // Sub-period pulse; outputs must drop to reset levels at once.
    #2 RESET = 1'b1;
    #1;
    chk("midrst d0", 32'(obs0), 32'(exp_vec(0, 16, 1)));
    chk("midrst d1", 32'(obs1), 32'(exp_vec(0, 4, 2)));
    #9 RESET = 1'b0;

    // Restart plus a long steady run.
    repeat (300) @(negedge CLK);
    #1;
    chk("stable rises d0", 32'(stab_rise0), 32'd2);
    chk("stable rises d1", 32'(stab_rise1), 32'd2);
    chk("sync falls d0",   32'(sr_fall0),   32'd2);
    chk("sync falls d1",   32'(sr_fall1),   32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
